// File: rtl/store_rs_queue.sv
// In-order store reservation queue: captures base/data operands from the CDB
// and dispatches ready stores oldest-first. Optional flush port: STORE_RSQ_FLUSH_EN.
module store_rs_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32,
    parameter int CDB_W  = 1 + TAG_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef STORE_RSQ_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       issue,
    input  logic [TAG_W-1:0]           q_base_in,
    input  logic [DATA_W-1:0]          base_in,
    input  logic [DATA_W-1:0]          offset_in,
    input  logic [TAG_W-1:0]           q_data_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [2:0]                 mem_u_b_h_w_in,
    input  logic [CDB_W-1:0]           cdb,
    input  logic                       st_taken,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       st_valid,
    output logic [DATA_W-1:0]          st_addr,
    output logic [DATA_W-1:0]          st_data,
    output logic [2:0]                 st_mem_u_b_h_w
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  busy;
    logic [TAG_W-1:0]  q_base      [DEPTH];
    logic [DATA_W-1:0] ent_base    [DEPTH];
    logic [DATA_W-1:0] ent_offset  [DEPTH];
    logic [DATA_W-1:0] ent_addr    [DEPTH];
    logic [TAG_W-1:0]  q_data      [DEPTH];
    logic [DATA_W-1:0] ent_data    [DEPTH];
    logic [2:0]        ent_ctrl    [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              do_issue;
    logic              do_take;
    logic              flush_now;
    logic              fwd_base_in;
    logic              fwd_data_in;

    assign cdb_valid = cdb[CDB_W-1];
    assign cdb_tag   = cdb[CDB_W-2:DATA_W];
    assign cdb_data  = cdb[DATA_W-1:0];

`ifdef STORE_RSQ_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // The address is written in the same cycle q_base clears, so a zero base
    // tag on a busy entry already implies a computed address.
    assign st_valid       = busy[head] && (q_base[head] == '0) && (q_data[head] == '0);
    assign st_addr        = ent_addr[head];
    assign st_data        = ent_data[head];
    assign st_mem_u_b_h_w = ent_ctrl[head];

    assign do_issue    = issue && !full;
    assign do_take     = st_taken && st_valid;
    assign fwd_base_in = cdb_valid && (q_base_in != '0) && (cdb_tag == q_base_in);
    assign fwd_data_in = cdb_valid && (q_data_in != '0) && (cdb_tag == q_data_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_base[i]     <= '0;
                ent_base[i]   <= '0;
                ent_offset[i] <= '0;
                ent_addr[i]   <= '0;
                q_data[i]     <= '0;
                ent_data[i]   <= '0;
                ent_ctrl[i]   <= '0;
            end
        end else if (flush_now) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_base[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            // Late forwarding: every waiting entry snoops the CDB in parallel.
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && cdb_valid && (cdb_tag != '0)) begin
                    if (q_base[i] == cdb_tag) begin
                        ent_base[i] <= cdb_data;
                        ent_addr[i] <= cdb_data + ent_offset[i];
                        q_base[i]   <= '0;
                    end
                    if (q_data[i] == cdb_tag) begin
                        ent_data[i] <= cdb_data;
                        q_data[i]   <= '0;
                    end
                end
            end

            if (do_issue) begin
                busy[tail]       <= 1'b1;
                ent_offset[tail] <= offset_in;
                ent_ctrl[tail]   <= mem_u_b_h_w_in;
                if (fwd_base_in) begin
                    ent_base[tail] <= cdb_data;
                    ent_addr[tail] <= cdb_data + offset_in;
                    q_base[tail]   <= '0;
                end else begin
                    ent_base[tail] <= base_in;
                    ent_addr[tail] <= base_in + offset_in;
                    q_base[tail]   <= q_base_in;
                end
                if (fwd_data_in) begin
                    ent_data[tail] <= cdb_data;
                    q_data[tail]   <= '0;
                end else begin
                    ent_data[tail] <= data_in;
                    q_data[tail]   <= q_data_in;
                end
                tail <= tail + PTR_W'(1);
            end

            if (do_take) begin
                busy[head] <= 1'b0;
                head       <= head + PTR_W'(1);
            end

            case ({do_issue, do_take})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
